// File: rtl/burst_div_pkg.sv
// Shared types for the multi-channel burst divider: channel FSM state and
// the per-channel configuration record. Field widths are fixed here; the top
// level width parameters default to these values.
package burst_div_pkg;

    localparam int CFG_CNT_W   = 10;
    localparam int CFG_REP_W   = 5;
    localparam int CFG_BURST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SILENT = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_e;

    typedef struct packed {
        logic [CFG_CNT_W-1:0]   m1;
        logic [CFG_CNT_W-1:0]   m2;
        logic [CFG_REP_W-1:0]   reps;
        logic [CFG_BURST_W-1:0] bursts;
    } ch_cfg_t;

    // Index of the final pulse in a burst; a repeat count of 0 behaves as 1.
    function automatic logic [CFG_REP_W-1:0] last_rep(input logic [CFG_REP_W-1:0] reps);
        return (reps == '0) ? '0 : reps - 1'b1;
    endfunction

endpackage

// File: rtl/burst_channel.sv
// One burst-divider channel: enable synchroniser, shadow/active config,
// IDLE/ACTIVE/SILENT/DONE FSM and its counters. Optional burst_end_o pulse
// exists only when BURST_END_IRQ_EN is defined.
module burst_channel
    import burst_div_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    enable_async_i,
    input  ch_cfg_t cfg_i,
    input  logic    cfg_load_i,
    output logic    clk_out_o,
    output logic    phase_status_o,
    output logic    done_o
`ifdef BURST_END_IRQ_EN
    ,
    output logic    burst_end_o
`endif
);

    localparam logic [CFG_CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [CFG_REP_W-1:0]   REP_ONE   = 1;
    localparam logic [CFG_BURST_W-1:0] BURST_ONE = 1;

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    en_s;
    ch_cfg_t                 shadow_q;
    ch_cfg_t                 act_q, act_d;
    ch_state_e               state_q, state_d;
    logic [CFG_CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_REP_W-1:0]    rep_q, rep_d;
    logic [CFG_BURST_W-1:0]  burst_q, burst_d, burst_inc;
    logic                    hi_q, hi_d;
    logic                    out_q, out_d;
    logic                    half_end, last_pulse, boundary;

    assign en_s = sync_q[SYNC_STAGES-1];

    // Enable synchroniser chain.
    always_ff @(posedge clk_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], enable_async_i};
    end

    // Shadow config, written by the load strobe in any state.
    always_ff @(posedge clk_i) begin
        if (reset_i)         shadow_q <= '0;
        else if (cfg_load_i) shadow_q <= cfg_i;
    end

    assign half_end   = (cnt_q == act_q.m1 - CNT_ONE);
    assign last_pulse = (rep_q == last_rep(act_q.reps));
    assign burst_inc  = burst_q + BURST_ONE;

    // Next-state logic; a burst boundary commits the pre-load shadow value.
    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        hi_d     = hi_q;
        burst_d  = burst_q;
        out_d    = out_q;
        boundary = 1'b0;
        if (!en_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rep_d   = '0;
            hi_d    = 1'b0;
            burst_d = '0;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Start uses the value about to be committed, not the stale active copy.
                    if (shadow_q.m1 != '0) begin
                        boundary = 1'b1;
                        burst_d  = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (!half_end) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = '0;
                        if (hi_q) begin
                            hi_d  = 1'b0;
                            out_d = 1'b0;
                        end else if (!last_pulse) begin
                            rep_d = rep_q + REP_ONE;
                            hi_d  = 1'b1;
                            out_d = 1'b1;
                        end else begin
                            // Unlimited mode leaves the counter parked at 0.
                            if (act_q.bursts != '0) burst_d = burst_inc;
                            if (act_q.bursts != '0 && burst_inc == act_q.bursts) begin
                                state_d = ST_DONE;
                                out_d   = 1'b0;
                            end else if (act_q.m2 != '0) begin
                                state_d = ST_SILENT;
                                out_d   = 1'b0;
                            end else begin
                                boundary = 1'b1;
                            end
                        end
                    end
                end
                ST_SILENT: begin
                    if (cnt_q == act_q.m2 - CNT_ONE) boundary = 1'b1;
                    else                             cnt_d = cnt_q + CNT_ONE;
                end
                default: ;
            endcase
            if (boundary) begin
                act_d = shadow_q;
                cnt_d = '0;
                rep_d = '0;
                if (shadow_q.m1 == '0) begin
                    state_d = ST_IDLE;
                    hi_d    = 1'b0;
                    out_d   = 1'b0;
                    burst_d = '0;
                end else begin
                    state_d = ST_ACTIVE;
                    hi_d    = 1'b1;
                    out_d   = 1'b1;
                end
            end
        end
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            cnt_q   <= '0;
            rep_q   <= '0;
            hi_q    <= 1'b0;
            burst_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            hi_q    <= hi_d;
            burst_q <= burst_d;
            out_q   <= out_d;
        end
    end

    assign clk_out_o      = out_q;
    assign phase_status_o = (state_q == ST_ACTIVE);
    assign done_o         = (state_q == ST_DONE);

`ifdef BURST_END_IRQ_EN
    // Last ACTIVE cycle of a burst that is actually completing.
    assign burst_end_o = (state_q == ST_ACTIVE) & ~hi_q & half_end & last_pulse & en_s & ~reset_i;
`endif

endmodule

// File: rtl/multi_channel_burst_divider.sv
// N independent burst-divider channels with shadowed config and finite burst
// count. Define BURST_END_IRQ_EN to add the per-channel burst_end pulse output.
module multi_channel_burst_divider
    import burst_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CFG_CNT_W,
    parameter int REP_W       = CFG_REP_W,
    parameter int BURST_W     = CFG_BURST_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         enable_async,
    input  logic [NUM_CH*CNT_W-1:0]   cfg_m1,
    input  logic [NUM_CH*CNT_W-1:0]   cfg_m2,
    input  logic [NUM_CH*REP_W-1:0]   cfg_repeat,
    input  logic [NUM_CH*BURST_W-1:0] cfg_bursts,
    input  logic [NUM_CH-1:0]         cfg_load,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         phase_status,
    output logic [NUM_CH-1:0]         done
`ifdef BURST_END_IRQ_EN
    ,
    output logic [NUM_CH-1:0]         burst_end
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_cfg_t cfg;

        assign cfg = {cfg_m1[i*CNT_W +: CNT_W], cfg_m2[i*CNT_W +: CNT_W],
                      cfg_repeat[i*REP_W +: REP_W], cfg_bursts[i*BURST_W +: BURST_W]};

        burst_channel #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk_i          (clk),
            .reset_i        (reset),
            .enable_async_i (enable_async[i]),
            .cfg_i          (cfg),
            .cfg_load_i     (cfg_load[i]),
            .clk_out_o      (clk_out[i]),
            .phase_status_o (phase_status[i]),
            .done_o         (done[i])
`ifdef BURST_END_IRQ_EN
            ,
            .burst_end_o    (burst_end[i])
`endif
        );
    end

endmodule

// File: tb/tb_multi_channel_burst_divider.sv
// Directed bench for multi_channel_burst_divider: waveforms are captured as
// '0'/'1' strings starting at a known edge and compared to hand-written ones.
module tb_multi_channel_burst_divider;

    localparam int NUM_CH = 4, CNT_W = 10, REP_W = 5, BURST_W = 8;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_CH-1:0]         enable_async = '0;
    logic [NUM_CH*CNT_W-1:0]   cfg_m1 = '0;
    logic [NUM_CH*CNT_W-1:0]   cfg_m2 = '0;
    logic [NUM_CH*REP_W-1:0]   cfg_repeat = '0;
    logic [NUM_CH*BURST_W-1:0] cfg_bursts = '0;
    logic [NUM_CH-1:0]         cfg_load = '0;
    logic [NUM_CH-1:0]         clk_out, phase_status, done;
`ifdef BURST_END_IRQ_EN
    logic [NUM_CH-1:0]         burst_end;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    multi_channel_burst_divider #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W), .BURST_W(BURST_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .enable_async(enable_async),
        .cfg_m1(cfg_m1), .cfg_m2(cfg_m2), .cfg_repeat(cfg_repeat), .cfg_bursts(cfg_bursts),
        .cfg_load(cfg_load), .clk_out(clk_out), .phase_status(phase_status), .done(done)
`ifdef BURST_END_IRQ_EN
        , .burst_end(burst_end)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_s(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int m1, input int m2, input int r, input int b);
        cfg_m1[ch*CNT_W +: CNT_W]         = CNT_W'(m1);
        cfg_m2[ch*CNT_W +: CNT_W]         = CNT_W'(m2);
        cfg_repeat[ch*REP_W +: REP_W]     = REP_W'(r);
        cfg_bursts[ch*BURST_W +: BURST_W] = BURST_W'(b);
        cfg_load[ch] = 1'b1;
        tick();
        cfg_load[ch] = 1'b0;
    endtask

    // Sample the current cycle, then advance; n samples, n edges.
    task automatic capture(input int ch, input int n, output string so, output string sp, output string sd);
        so = ""; sp = ""; sd = "";
        for (int i = 0; i < n; i++) begin
            so = {so, clk_out[ch] ? "1" : "0"};
            sp = {sp, phase_status[ch] ? "1" : "0"};
            sd = {sd, done[ch] ? "1" : "0"};
            tick();
        end
    endtask

    initial begin
        string so, sp, sd, e;

        // Reset state
        tick(); tick(); tick();
        check_v("rst_clk_out", 32'(clk_out), 32'h0);
        check_v("rst_phase", 32'(phase_status), 32'h0);
        check_v("rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        tick();
        check_v("post_rst_idle", 32'(clk_out), 32'h0);

        // Ch0: M1=2 M2=10 R=4 unlimited, 26-cycle period
        set_cfg(0, 2, 10, 4, 0);
        enable_async[0] = 1'b1;
        tick(); tick();
        check_v("t1_latency_low", 32'(clk_out[0]), 32'h0);
        tick();
        capture(0, 52, so, sp, sd);
        e = {"1100110011001100", "0000000000", "1100110011001100", "0000000000"};
        check_s("t1_clk_out", so, e);
        e = {"1111111111111111", "0000000000", "1111111111111111", "0000000000"};
        check_s("t1_phase", sp, e);

        // Ch0 reconfig one cycle into a burst: old burst + old silence finish first
        set_cfg(0, 1, 5, 2, 0);
        capture(0, 43, so, sp, sd);
        e = {"1", "00", "110011001100", "0000000000", "101000000", "101000000"};
        check_s("t3_reconfig", so, e);

        // Ch1: M1=3 M2=0 R=5 continuous square wave
        set_cfg(1, 3, 0, 5, 0);
        enable_async[1] = 1'b1;
        tick(); tick(); tick();
        capture(1, 40, so, sp, sd);
        e = {"111000111000111000111000111000111000", "1110"};
        check_s("t2_clk_out", so, e);
        e = {"1111111111", "1111111111", "1111111111", "1111111111"};
        check_s("t2_phase", sp, e);

        // Ch1: drop enable mid-burst, then restart from pulse 1
        enable_async[1] = 1'b0;
        tick(); tick(); tick();
        check_v("t5_drop_clk", 32'(clk_out[1]), 32'h0);
        check_v("t5_drop_phase", 32'(phase_status[1]), 32'h0);
        tick(); tick();
        enable_async[1] = 1'b1;
        tick(); tick();
        check_v("t5_reen_latency", 32'(clk_out[1]), 32'h0);
        tick();
        capture(1, 9, so, sp, sd);
        check_s("t5_restart", so, "111000111");

        // Ch2: 3 bursts of M1=1 R=2 M2=4, then DONE without trailing silence
        set_cfg(2, 1, 4, 2, 3);
        enable_async[2] = 1'b1;
        tick(); tick(); tick();
        capture(2, 24, so, sp, sd);
        e = {"10100000", "10100000", "1010", "0000"};
        check_s("t4_clk_out", so, e);
        e = {"0000000000", "0000000000", "1111"};
        check_s("t4_done", sd, e);
        enable_async[2] = 1'b0;
        tick(); tick();
        check_v("t4_done_hold", 32'(done[2]), 32'h1);
        tick();
        check_v("t4_done_clear", 32'(done[2]), 32'h0);

        // Ch3: M1=4 M2=2 R=1 alongside the others
        set_cfg(3, 4, 2, 1, 0);
        enable_async[3] = 1'b1;
        tick(); tick(); tick();
        capture(3, 20, so, sp, sd);
        check_s("t6_ch3", so, "11110000001111000000");

        // Reset mid-stream clears all channels, shadows included
        reset = 1'b1;
        tick();
        check_v("t6_rst_clk_out", 32'(clk_out), 32'h0);
        check_v("t6_rst_phase", 32'(phase_status), 32'h0);
        check_v("t6_rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        check_v("t6_no_restart", 32'(clk_out) | 32'(phase_status), 32'h0);

        // R=0 acts as a single pulse; start happens the edge after the load
        set_cfg(3, 2, 1, 0, 0);
        check_v("r0_start_delay", 32'(clk_out[3]), 32'h0);
        tick();
        capture(3, 10, so, sp, sd);
        check_s("r0_clk_out", so, "1100011000");

        // Loading M1=0 mid-burst drops the channel to IDLE at the next boundary
        set_cfg(3, 0, 1, 0, 0);
        capture(3, 8, so, sp, sd);
        check_s("m1zero_clk_out", so, "10000000");
        check_s("m1zero_phase", sp, "11100000");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
